// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches 32-bit instruction words from an external
// memory with a fixed read latency, decodes them into I2C read/write
// commands, hands them to an I2C master and reports read results. Execution
// either finishes after the last instruction or loops back to LOOP_START.
module instruction_sequencer #(
  parameter int NO_OF_BITS   = 8,
  parameter int PROG_LEN     = 4,
  parameter int LOOP_START   = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  loop_en,
  output logic [NO_OF_BITS-1:0] reg_addr,
  input  logic [31:0]           read_data,
  input  logic [3:0]            error_code,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_rw,
  output logic [7:0]            cmd_dev,
  output logic [7:0]            cmd_reg,
  output logic [7:0]            cmd_wdata,
  input  logic                  rsp_valid,
  input  logic [7:0]            rsp_data,
  input  logic                  rsp_err,
  output logic                  result_valid,
  output logic [7:0]            result_reg,
  output logic [7:0]            result_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [3:0]            fault_code
);

  localparam logic [NO_OF_BITS-1:0] LAST_ADDR = NO_OF_BITS'(PROG_LEN - 1);
  localparam logic [NO_OF_BITS-1:0] WRAP_ADDR = NO_OF_BITS'(LOOP_START);
  localparam int                    CNT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(READ_LATENCY - 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_RSP,
    NEXT,
    DONE,
    FAULT
  } state_t;

  state_t           state_reg;
  logic [31:0]      instr_reg;    // captured instruction word
  logic [3:0]       err_reg;      // error code captured with the instruction
  logic [CNT_W-1:0] lat_cnt_reg;  // clocks elapsed since reg_addr was updated

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      instr_reg    <= '0;
      err_reg      <= '0;
      lat_cnt_reg  <= '0;
      reg_addr     <= '0;
      cmd_valid    <= 1'b0;
      cmd_rw       <= 1'b0;
      cmd_dev      <= '0;
      cmd_reg      <= '0;
      cmd_wdata    <= '0;
      result_valid <= 1'b0;
      result_reg   <= '0;
      result_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= '0;
    end else begin
      // result_valid is a single-cycle strobe
      result_valid <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg   <= FETCH;
            reg_addr    <= '0;
            lat_cnt_reg <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        FETCH: begin
          // The word for reg_addr is valid on the READ_LATENCY-th edge after the update
          if (lat_cnt_reg == CNT_LAST) begin
            instr_reg <= read_data;
            err_reg   <= error_code;
            state_reg <= DECODE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
        DECODE: begin
          if (err_reg != 4'd0) begin
            state_reg  <= FAULT;
            fault      <= 1'b1;
            fault_code <= 4'd1;
            busy       <= 1'b0;
          end else begin
            case (instr_reg[31:24])
              OP_NOP: state_reg <= NEXT;
              OP_READ, OP_WRITE: begin
                state_reg <= ISSUE;
                cmd_valid <= 1'b1;
                cmd_rw    <= (instr_reg[31:24] == OP_READ);
                cmd_dev   <= instr_reg[23:16];
                cmd_reg   <= instr_reg[15:8];
                cmd_wdata <= instr_reg[7:0];
              end
              default: begin
                state_reg  <= FAULT;
                fault      <= 1'b1;
                fault_code <= 4'd2;
                busy       <= 1'b0;
              end
            endcase
          end
        end
        ISSUE: begin
          // cmd_valid is high throughout ISSUE; fields stay put until accepted
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state_reg <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_err) begin
              state_reg  <= FAULT;
              fault      <= 1'b1;
              fault_code <= 4'd3;
              busy       <= 1'b0;
            end else begin
              if (cmd_rw) begin
                result_valid <= 1'b1;
                result_reg   <= instr_reg[15:8];
                result_data  <= rsp_data;
              end
              state_reg <= NEXT;
            end
          end
        end
        NEXT: begin
          if (reg_addr < LAST_ADDR) begin
            reg_addr    <= reg_addr + 1'b1;
            lat_cnt_reg <= '0;
            state_reg   <= FETCH;
          end else if (loop_en) begin
            reg_addr    <= WRAP_ADDR;
            lat_cnt_reg <= '0;
            state_reg   <= FETCH;
          end else begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        FAULT: begin
          // Sticky until reset
          state_reg <= FAULT;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a registered instruction memory, a
// randomized I2C-master responder and a program-walking reference model.
module tb_instruction_sequencer;

  localparam int PL = 4;
  localparam int LS = 2;

  logic        clk = 1'b0;
  logic        reset, start, loop_en;
  logic [7:0]  reg_addr;
  logic [31:0] read_data;
  logic [3:0]  error_code;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [7:0]  cmd_dev, cmd_reg, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic        result_valid;
  logic [7:0]  result_reg, result_data;
  logic        busy, done, fault;
  logic [3:0]  fault_code;

  instruction_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .loop_en(loop_en),
    .reg_addr(reg_addr), .read_data(read_data), .error_code(error_code),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .result_valid(result_valid), .result_reg(result_reg), .result_data(result_data),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Instruction memory: one register stage, so the word is valid two edges after reg_addr moves
  logic [31:0] mem  [0:255];
  logic [3:0]  emem [0:255];
  always @(posedge clk) begin
    read_data  <= mem[reg_addr];
    error_code <= emem[reg_addr];
  end

  typedef struct packed {
    logic       rw;
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
  } cmd_t;

  cmd_t        obs_cmd[$], exp_cmd[$];
  logic [15:0] obs_res[$], exp_res[$];
  logic [7:0]  obs_addr[$], exp_addr[$], sent[$];
  int          n_pass = 0, n_fail = 0, n_total = 0;
  int          valid_seen, stall_seen, exp_fc;
  bit          exp_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t norm(input cmd_t c);
    cmd_t r = c;
    if (r.rw) r.wd = 8'h00;  // write data is only meaningful for writes
    return r;
  endfunction

  task automatic load_default();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0;
      emem[i] = 4'h0;
    end
    mem[0] = 32'h011d0000;
    mem[1] = 32'h021d2d08;
    mem[2] = 32'h011d3200;
    mem[3] = 32'h011d3300;
  endtask

  task automatic load_random();
    logic [7:0] op;
    int r;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0;
      emem[i] = 4'h0;
    end
    for (int i = 0; i < PL; i++) begin
      r = $urandom_range(0, 19);
      if (r < 3)       op = 8'h00;
      else if (r < 10) op = 8'h01;
      else if (r < 18) op = 8'h02;
      else             op = 8'($urandom_range(3, 255));
      mem[i] = {op, 8'($urandom), 8'($urandom), (op == 8'h01) ? 8'h00 : 8'($urandom)};
      if ($urandom_range(0, 15) == 0) emem[i] = 4'($urandom_range(1, 15));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_cmd", tag), 64'({cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata}), 64'd0);
    check($sformatf("%s_result", tag), 64'({result_valid, result_reg, result_data}), 64'd0);
    check($sformatf("%s_status", tag), 64'({busy, done, fault, fault_code}), 64'd0);
    check($sformatf("%s_addr", tag), 64'(reg_addr), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  // Start the program and act as the I2C master until the sequencer goes idle or the budget runs out
  task automatic run_prog(input int budget, input bit lp, input int err_at, input bit stall, input bit rand_start);
    int   outstanding = 0, delay = 0, resp_cnt = 0, stall_left;
    bit   prev_valid = 1'b0, prev_acc = 1'b0, acc;
    cmd_t cur, prev_cmd;
    logic [7:0] last_addr;
    obs_cmd.delete(); obs_res.delete(); obs_addr.delete(); sent.delete();
    valid_seen = 0; stall_seen = 0;
    stall_left = stall ? 5 : 0;
    prev_cmd = '0;
    loop_en = lp;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clear", 64'(done), 64'd0);
    check("start_addr", 64'(reg_addr), 64'd0);
    last_addr = reg_addr;
    obs_addr.push_back(reg_addr);
    for (int c = 0; c < budget && busy === 1'b1; c++) begin
      if (reg_addr != last_addr) begin
        obs_addr.push_back(reg_addr);
        last_addr = reg_addr;
      end
      if (result_valid) obs_res.push_back({result_reg, result_data});
      rsp_valid = 1'b0; rsp_err = 1'b0; start = 1'b0;
      cur = '{rw: cmd_rw, dev: cmd_dev, rg: cmd_reg, wd: cmd_wdata};
      if (cmd_valid) valid_seen++;
      if (cmd_valid && prev_valid && !prev_acc) check("cmd_hold", 64'(cur), 64'(prev_cmd));
      if (cmd_valid && stall_left > 0) begin
        cmd_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end else if (cmd_valid) begin
        cmd_ready = ($urandom_range(0, 2) != 0);
      end else begin
        cmd_ready = 1'($urandom_range(0, 1));
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        obs_cmd.push_back(cur);
        outstanding = 1;
        delay = $urandom_range(1, 3);
      end else if (outstanding != 0) begin
        delay--;
        if (delay == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = 8'($urandom);
          rsp_err   = (resp_cnt == err_at);
          sent.push_back(rsp_data);
          resp_cnt++;
          outstanding = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // stray completion while nothing is outstanding must be ignored
        rsp_valid = 1'b1;
        rsp_err   = 1'($urandom_range(0, 1));
        rsp_data  = 8'($urandom);
      end
      if (rand_start && busy && $urandom_range(0, 9) == 0) start = 1'b1;
      prev_valid = cmd_valid; prev_cmd = cur; prev_acc = acc;
      @(negedge clk);
    end
    start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
  endtask

  // Walk the program instruction by instruction, pairing each command with the response the bench sent
  task automatic model(input bit lp, input int err_at, input int limit);
    int a = 0, k = 0;
    logic [31:0] w;
    logic [7:0]  op;
    cmd_t c;
    exp_cmd.delete(); exp_res.delete(); exp_addr.delete();
    exp_fc = 0; exp_done = 1'b0;
    exp_addr.push_back(8'(a));
    for (int s = 0; s < 2000; s++) begin
      w  = mem[a];
      op = w[31:24];
      if (emem[a] != 4'd0) begin exp_fc = 1; break; end
      if (op == 8'h01 || op == 8'h02) begin
        if (exp_cmd.size() >= limit) break;
        c = '{rw: (op == 8'h01), dev: w[23:16], rg: w[15:8], wd: w[7:0]};
        exp_cmd.push_back(c);
        if (k >= sent.size()) break;
        if (k == err_at) begin exp_fc = 3; break; end
        if (op == 8'h01) exp_res.push_back({w[15:8], sent[k]});
        k++;
      end else if (op != 8'h00) begin
        exp_fc = 2;
        break;
      end
      if (a == PL - 1) begin
        if (!lp) begin exp_done = 1'b1; break; end
        a = LS;
      end else begin
        a++;
      end
      exp_addr.push_back(8'(a));
    end
  endtask

  task automatic compare_all(input bit lp);
    int n;
    if (!lp) begin
      check("n_cmds", 64'(obs_cmd.size()), 64'(exp_cmd.size()));
      check("n_results", 64'(obs_res.size()), 64'(exp_res.size()));
      check("n_addrs", 64'(obs_addr.size()), 64'(exp_addr.size()));
    end
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) check($sformatf("cmd%0d", i), 64'(norm(obs_cmd[i])), 64'(norm(exp_cmd[i])));
    n = (obs_res.size() < exp_res.size()) ? obs_res.size() : exp_res.size();
    for (int i = 0; i < n; i++) check($sformatf("result%0d", i), 64'(obs_res[i]), 64'(exp_res[i]));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) check($sformatf("addr%0d", i), 64'(obs_addr[i]), 64'(exp_addr[i]));
  endtask

  task automatic check_status(input bit lp);
    check("fault", 64'(fault), 64'(exp_fc != 0));
    check("fault_code", 64'(fault_code), 64'(exp_fc));
    if (lp && exp_fc == 0) begin
      check("loop_busy", 64'(busy), 64'd1);
      check("loop_done", 64'(done), 64'd0);
    end else begin
      check("done", 64'(done), 64'(exp_done));
      check("busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic fault_sticky(input int fc);
    logic [7:0] a0 = reg_addr;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("sticky_fault", 64'(fault), 64'd1);
    check("sticky_code", 64'(fault_code), 64'(fc));
    check("sticky_idle", 64'({busy, done, cmd_valid}), 64'd0);
    check("sticky_addr", 64'(reg_addr), 64'(a0));
  endtask

  task automatic reset_in_wait();
    bit got = 1'b0;
    loop_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmd_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("rst_wait_cmd_seen", 64'(got), 64'd1);
    cmd_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0;
    check("rst_wait_busy", 64'(busy), 64'd1);
    check("rst_wait_cmd_drop", 64'(cmd_valid), 64'd0);
    rsp_valid = 1'b1; rsp_err = 1'b0; rsp_data = 8'hA5; reset = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0; reset = 1'b0;
    check_reset_outputs("rst_wait");
    repeat (4) begin
      @(negedge clk);
      check("rst_wait_no_result", 64'(result_valid), 64'd0);
      check("rst_wait_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    bit lp;
    int err_at;
    reset = 1'b1; start = 1'b0; loop_en = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 8'h00;
    load_default();
    do_reset();

    // Default program with a 5-clock stall on the first command and stray starts
    run_prog(300, 1'b0, -1, 1'b1, 1'b1);
    model(1'b0, -1, 1000);
    compare_all(1'b0);
    check_status(1'b0);
    check("stall_cycles", 64'(stall_seen), 64'd5);
    check("default_n_results", 64'(obs_res.size()), 64'd3);
    check("default_done", 64'(done), 64'd1);

    // Restart from DONE
    run_prog(300, 1'b0, -1, 1'b0, 1'b0);
    model(1'b0, -1, 1000);
    compare_all(1'b0);
    check_status(1'b0);

    // Looping: 0x32/0x33 reads repeat from LOOP_START
    do_reset();
    run_prog(400, 1'b1, -1, 1'b0, 1'b1);
    model(1'b1, -1, obs_cmd.size());
    compare_all(1'b1);
    check_status(1'b1);
    check("loop_progress", 64'(obs_cmd.size() >= 8), 64'd1);
    if (obs_addr.size() > 4) check("loop_wrap_addr", 64'(obs_addr[4]), 64'd2);
    else check("loop_addr_count", 64'(obs_addr.size()), 64'd5);

    // NACK on the first read
    do_reset();
    run_prog(300, 1'b0, 0, 1'b0, 1'b0);
    model(1'b0, 0, 1000);
    compare_all(1'b0);
    check_status(1'b0);
    check("nack_no_result", 64'(obs_res.size()), 64'd0);
    fault_sticky(3);

    // Illegal opcode
    do_reset();
    load_default();
    mem[0] = 32'h071d0000;
    run_prog(300, 1'b0, -1, 1'b0, 1'b0);
    model(1'b0, -1, 1000);
    compare_all(1'b0);
    check_status(1'b0);
    check("bad_op_no_valid", 64'(valid_seen), 64'd0);
    fault_sticky(2);

    // Memory error on address 2
    do_reset();
    load_default();
    emem[2] = 4'd1;
    run_prog(300, 1'b0, -1, 1'b0, 1'b0);
    model(1'b0, -1, 1000);
    compare_all(1'b0);
    check_status(1'b0);
    fault_sticky(1);

    // Reset while waiting for a response that arrives on the same edge
    load_default();
    do_reset();
    reset_in_wait();

    // Random programs
    repeat (8) begin
      do_reset();
      load_random();
      lp = 1'($urandom_range(0, 1));
      err_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1;
      run_prog(lp ? 200 : 300, lp, err_at, 1'b0, 1'b1);
      model(lp, err_at, lp ? obs_cmd.size() : 1000);
      compare_all(lp);
      check_status(lp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter NO_OF_BITS, default 8: width of the instruction-memory address.
REQ-002 SHALL have parameter PROG_LEN, default 4: number of instructions, at addresses 0..PROG_LEN-1.
REQ-003 SHALL have parameter LOOP_START, default 2: address to jump back to after the last instruction when looping.
REQ-004 SHALL have parameter READ_LATENCY, default 2: clocks from a reg_addr update to read_data being valid.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins execution at address 0.
REQ-008 SHALL have port loop_en, input, 1 bit: when set, execution repeats from LOOP_START instead of finishing.
REQ-009 SHALL have port reg_addr, output, NO_OF_BITS bits: registered instruction-memory address.
REQ-010 SHALL have port read_data, input, 32 bits: instruction word, fields op[31:24] | dev[23:16] | reg[15:8] | data[7:0].
REQ-011 SHALL have port error_code, input, 4 bits: instruction-memory error; nonzero means an invalid address.
REQ-012 SHALL have port cmd_valid, output, 1 bit: an I2C command is offered.
REQ-013 SHALL have port cmd_ready, input, 1 bit: the I2C master accepts the command.
REQ-014 SHALL have port cmd_rw, output, 1 bit: 1 = read, 0 = write.
REQ-015 SHALL have ports cmd_dev, cmd_reg and cmd_wdata, outputs, 8 bits each: device, register and write data.
REQ-016 SHALL have ports rsp_valid (input, 1 bit), rsp_data (input, 8 bits) and rsp_err (input, 1 bit): I2C completion, read byte, and NACK/bus error.
REQ-017 SHALL have ports result_valid (output, 1 bit), result_reg (output, 8 bits) and result_data (output, 8 bits): read-result strobe, source register and read byte.
REQ-018 SHALL have ports busy (output, 1 bit), done (output, 1 bit), fault (output, 1 bit) and fault_code (output, 4 bits): status.

Function
REQ-019 SHALL implement the states IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, NEXT, DONE and FAULT.
REQ-020 IDLE: SHALL go to FETCH on start, set reg_addr = 0 and assert busy.
REQ-021 FETCH: SHALL count READ_LATENCY clocks after the reg_addr update, then capture read_data and error_code on that edge, giving exactly 2 clocks fetch-to-capture at the default.
REQ-022 DECODE: if the captured error_code != 0, SHALL go to FAULT with fault_code = 1.
REQ-023 DECODE: op 0x00 (NOP) SHALL go to NEXT, op 0x01 to ISSUE with cmd_rw = 1, op 0x02 to ISSUE with cmd_rw = 0.
REQ-024 DECODE: any other op SHALL go to FAULT with fault_code = 2.
REQ-025 ISSUE: SHALL hold cmd_valid high with cmd_rw, cmd_dev, cmd_reg and cmd_wdata stable until the cycle where cmd_valid && cmd_ready, then deassert cmd_valid the next cycle and go to WAIT_RSP.
REQ-026 WAIT_RSP: on rsp_valid with rsp_err = 1, SHALL go to FAULT with fault_code = 3.
REQ-027 WAIT_RSP: on rsp_valid with rsp_err = 0 for a read, SHALL pulse result_valid for 1 clock with result_reg = the instruction's reg field and result_data = rsp_data.
REQ-028 WAIT_RSP: on rsp_valid with rsp_err = 0 for a write, SHALL go to NEXT with no result pulse.
REQ-029 SHALL ignore rsp_valid in every state other than WAIT_RSP.
REQ-030 NEXT: if reg_addr < PROG_LEN-1, SHALL increment reg_addr and go to FETCH.
REQ-031 NEXT: at reg_addr == PROG_LEN-1, SHALL set reg_addr = LOOP_START and go to FETCH if loop_en is sampled at that cycle, else go to DONE.
REQ-032 DONE: SHALL assert done and deassert busy, and a new start SHALL restart from address 0 and clear done.
REQ-033 FAULT: SHALL assert fault with fault_code held and busy low, leave only on reset, and ignore start.
REQ-034 SHALL ignore start while busy.
REQ-035 SHALL apply the same rules at the LOOP_START wrap as at address 0 (no skipped fetch).
REQ-036 SHALL give reset precedence over every simultaneous event (start, cmd_ready, rsp_valid).

Reset
REQ-037 While reset is high at a clock edge, the block SHALL enter IDLE and drive reg_addr = 0, cmd_valid = 0, cmd_rw = 0, cmd_dev/cmd_reg/cmd_wdata = 0, result_valid = 0, result_reg/result_data = 0, busy = 0, done = 0, fault = 0 and fault_code = 0.
REQ-038 Reset mid-transaction SHALL drop cmd_valid on the next edge and discard any pending response.

Verification
REQ-039 The bench SHALL cover: default program {01_1d_00_00, 02_1d_2d_08, 01_1d_32_00, 01_1d_33_00}, loop_en = 0, start -> ISSUE sequence read 0x1d/0x00, write 0x1d/0x2d/0x08, read 0x32, read 0x33; 3 result_valid pulses; then done = 1.
REQ-040 The bench SHALL cover: cmd_ready held low 5 clocks in ISSUE -> cmd_valid and all cmd fields stable for all 5 clocks; exactly one command accepted.
REQ-041 The bench SHALL cover: loop_en = 1 -> after address 3, reg_addr = 2, and reads of 0x32/0x33 alternate indefinitely with busy = 1 and done = 0.
REQ-042 The bench SHALL cover: memory returning op 0x07 -> fault = 1, fault_code = 2, no cmd_valid; later error_code = 1 -> fault_code = 1.
REQ-043 The bench SHALL cover: rsp_err = 1 on the first read -> fault_code = 3, no result_valid; then start ignored until reset.
REQ-044 The bench SHALL cover: reset asserted during WAIT_RSP together with rsp_valid -> IDLE next edge, all outputs at reset values, no result_valid.
